// File: rtl/product_accumulator_pkg.sv
// Shared multiplier package: product width, saturation limits and the
// accumulator state encoding used by the Booth multiplier datapath.
package product_accumulator_pkg;
   localparam int PRODUCT_W = 64;
   localparam logic [PRODUCT_W-1:0] SAT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [PRODUCT_W-1:0] SAT_MIN = 64'h8000_0000_0000_0000;

   typedef enum logic {
      ST_ACCUM  = 1'b0,
      ST_OUTPUT = 1'b1
   } acc_state_e;
endpackage

// File: rtl/product_accumulator_sat_clamp.sv
// Combinational clamp of a wide signed accumulator to a 64-bit signed result,
// flagging whenever the value had to be limited.
module sat_clamp
   import product_accumulator_pkg::*;
#(
   parameter int ACC_W = 72
) (
   input  logic [ACC_W-1:0]     i_acc,
   output logic [PRODUCT_W-1:0] o_sum,
   output logic                 o_ovf
);
   // The value fits when every bit from 63 upward is a copy of the sign.
   logic [ACC_W-PRODUCT_W:0] w_top;
   logic                     w_in_range;

   assign w_top      = i_acc[ACC_W-1:PRODUCT_W-1];
   assign w_in_range = (&w_top) | ~(|w_top);

   // Select the pass-through value or the saturation limit of matching sign.
   always_comb begin
      o_sum = i_acc[PRODUCT_W-1:0];
      o_ovf = 1'b0;
      if (!w_in_range) begin
         o_ovf = 1'b1;
         if (i_acc[ACC_W-1]) begin
            o_sum = SAT_MIN;
         end else begin
            o_sum = SAT_MAX;
         end
      end else begin
         o_sum = i_acc[PRODUCT_W-1:0];
      end
   end
endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of BLOCK_LEN signed products and hands out a saturated 64-bit
// block sum with a valid/ready handshake; flush emits a partial block early.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int BLOCK_LEN = 8,
   parameter int ACC_W     = 72
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic [PRODUCT_W-1:0] productIn,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic                 clearAcc,
   input  logic                 flush,
   output logic [PRODUCT_W-1:0] sumOut,
   output logic [7:0]           sumCount,
   output logic                 overflow,
   output logic                 sumValid,
   input  logic                 sumReady
);
   localparam logic [7:0] BLOCK_LEN_C = 8'(BLOCK_LEN);

   acc_state_e           r_state;
   acc_state_e           w_state_next;
   logic [ACC_W-1:0]     r_acc;
   logic [ACC_W-1:0]     w_acc_next;
   logic [7:0]           r_count;
   logic [7:0]           w_count_next;
   logic [7:0]           w_count_inc;
   logic                 w_accept;
   logic                 w_capture;
   logic [ACC_W-1:0]     w_prod_ext;
   logic [PRODUCT_W-1:0] w_clamped;
   logic                 w_ovf;

   assign inReady     = (r_state == ST_ACCUM) && !clearAcc;
   assign w_accept    = inValid && inReady;
   assign w_count_inc = r_count + 8'd1;
   assign w_prod_ext  = {{(ACC_W-PRODUCT_W){productIn[PRODUCT_W-1]}}, productIn};

   // Clamp sees the post-edge accumulator so the result captured on the
   // closing edge already includes a product accepted on that same edge.
   sat_clamp #(.ACC_W(ACC_W)) u_sat_clamp (
      .i_acc (w_acc_next),
      .o_sum (w_clamped),
      .o_ovf (w_ovf)
   );

   // Next-state and accumulator update.
   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_count_next = r_count;
      w_capture    = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            if (clearAcc) begin
               w_acc_next   = {ACC_W{1'b0}};
               w_count_next = 8'd0;
            end else if (w_accept) begin
               w_acc_next   = r_acc + w_prod_ext;
               w_count_next = w_count_inc;
               if ((w_count_inc == BLOCK_LEN_C) || flush) begin
                  w_state_next = ST_OUTPUT;
                  w_capture    = 1'b1;
               end else begin
                  w_state_next = ST_ACCUM;
               end
            end else if (flush && (r_count != 8'd0)) begin
               w_state_next = ST_OUTPUT;
               w_capture    = 1'b1;
            end else begin
               w_state_next = ST_ACCUM;
            end
         end
         ST_OUTPUT: begin
            if (sumReady) begin
               w_state_next = ST_ACCUM;
               w_acc_next   = {ACC_W{1'b0}};
               w_count_next = 8'd0;
            end else begin
               w_state_next = ST_OUTPUT;
            end
         end
         default: begin
            w_state_next = ST_ACCUM;
            w_acc_next   = {ACC_W{1'b0}};
            w_count_next = 8'd0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Accumulator and product count.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_acc   <= {ACC_W{1'b0}};
         r_count <= 8'd0;
      end else begin
         r_acc   <= w_acc_next;
         r_count <= w_count_next;
      end
   end

   // Result registers: loaded only when a block closes, held while waiting.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sumOut   <= {PRODUCT_W{1'b0}};
         sumCount <= 8'd0;
         overflow <= 1'b0;
         sumValid <= 1'b0;
      end else begin
         sumValid <= (w_state_next == ST_OUTPUT);
         if (w_capture) begin
            sumOut   <= w_clamped;
            sumCount <= w_count_next;
            overflow <= w_ovf;
         end
      end
   end
endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a 128-bit reference model predicts each block result when
// it closes; results are compared while pending and popped on consumption.
module tb_product_accumulator;
   logic        clk;
   logic        resetN;
   logic [63:0] productIn;
   logic        inValid;
   logic        inReady;
   logic        clearAcc;
   logic        flush;
   logic [63:0] sumOut;
   logic [7:0]  sumCount;
   logic        overflow;
   logic        sumValid;
   logic        sumReady;

   typedef struct {
      logic [63:0] sum;
      logic [7:0]  cnt;
      logic        ovf;
   } exp_t;

   localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [127:0] MINV = -MAXV - 128'sd1;

   exp_t               exp_q[$];
   logic signed [127:0] m_acc;
   int                  m_cnt;
   logic                m_out;
   int                  n_checks;
   int                  n_err;
   int                  n_blocks;

   product_accumulator dut (
      .clk       (clk),
      .resetN    (resetN),
      .productIn (productIn),
      .inValid   (inValid),
      .inReady   (inReady),
      .clearAcc  (clearAcc),
      .flush     (flush),
      .sumOut    (sumOut),
      .sumCount  (sumCount),
      .overflow  (overflow),
      .sumValid  (sumValid),
      .sumReady  (sumReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model, evaluated on the falling edge for the coming rising edge.
   task automatic run_monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!resetN) begin
            m_acc = '0;
            m_cnt = 0;
            m_out = 1'b0;
            exp_q.delete();
         end else begin
            check_val("inReady", inReady, {63'd0, !m_out && !clearAcc});
            check_val("sumValid", sumValid, {63'd0, m_out});
            if (m_out) begin
               if (exp_q.size() == 0) begin
                  check_val("queue_empty", 64'd1, 64'd0);
               end else begin
                  e = exp_q[0];
                  check_val("sumOut", sumOut, e.sum);
                  check_val("sumCount", {56'd0, sumCount}, {56'd0, e.cnt});
                  check_val("overflow", {63'd0, overflow}, {63'd0, e.ovf});
                  if (sumReady) begin
                     void'(exp_q.pop_front());
                     m_out = 1'b0;
                     m_acc = '0;
                     m_cnt = 0;
                     n_blocks++;
                  end
               end
            end else if (clearAcc) begin
               m_acc = '0;
               m_cnt = 0;
            end else if (inValid || (flush && m_cnt > 0)) begin
               if (inValid) begin
                  m_acc = m_acc + {{64{productIn[63]}}, productIn};
                  m_cnt = m_cnt + 1;
               end
               if (m_cnt == 8 || flush) begin
                  e.cnt = 8'(m_cnt);
                  if (m_acc > MAXV) begin
                     e.sum = 64'h7FFF_FFFF_FFFF_FFFF;
                     e.ovf = 1'b1;
                  end else if (m_acc < MINV) begin
                     e.sum = 64'h8000_0000_0000_0000;
                     e.ovf = 1'b1;
                  end else begin
                     e.sum = m_acc[63:0];
                     e.ovf = 1'b0;
                  end
                  exp_q.push_back(e);
                  m_out = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drv(input logic v, input logic [63:0] p, input logic fl,
                      input logic clr, input logic rdy);
      inValid   = v;
      productIn = p;
      flush     = fl;
      clearAcc  = clr;
      sumReady  = rdy;
      tick();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) drv(1'b0, 64'd0, 1'b0, 1'b0, rdy);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear at once.
   task automatic pulse_reset(input string tag);
      resetN = 1'b0;
      #1;
      check_val({tag, "_sumValid"}, {63'd0, sumValid}, 64'd0);
      check_val({tag, "_sumOut"}, sumOut, 64'd0);
      check_val({tag, "_sumCount"}, {56'd0, sumCount}, 64'd0);
      check_val({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
      #5;
      resetN = 1'b1;
      tick();
   endtask

   initial begin
      logic [31:0] r32;
      logic [63:0] p;
      n_checks  = 0;
      n_err     = 0;
      n_blocks  = 0;
      m_acc     = '0;
      m_cnt     = 0;
      m_out     = 1'b0;
      resetN    = 1'b0;
      inValid   = 1'b0;
      productIn = 64'd0;
      clearAcc  = 1'b0;
      flush     = 1'b0;
      sumReady  = 1'b0;
      fork
         run_monitor();
      join_none
      #1;
      check_val("rst_sumValid", {63'd0, sumValid}, 64'd0);
      check_val("rst_sumOut", sumOut, 64'd0);
      check_val("rst_sumCount", {56'd0, sumCount}, 64'd0);
      check_val("rst_overflow", {63'd0, overflow}, 64'd0);
      repeat (2) @(posedge clk);
      #2;
      resetN = 1'b1;

      // Full block of a constant product, first accept right after release.
      for (int i = 0; i < 8; i++) drv(1'b1, 64'h0000_0000_1BB6_BAA0, 1'b0, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Partial block closed by flush.
      drv(1'b1, 64'hFFFF_FFFF_F774_7564, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 64'h0000_0000_0001_0609, 1'b0, 1'b0, 1'b1);
      drv(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Saturation in both directions; flush with empty block is ignored.
      drv(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) drv(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);
      for (int i = 0; i < 8; i++) drv(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Backpressure: block held 5 cycles with inValid still asserted.
      for (int i = 0; i < 13; i++) drv(1'b1, 64'd5 + 64'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drv(1'b1, 64'd3, 1'b0, 1'b0, 1'b1);
      drv(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      idle(2, 1'b1);

      // clearAcc beats inValid and flush, then a clean block of ones.
      for (int i = 0; i < 3; i++) drv(1'b1, 64'd100, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 64'd77, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) drv(1'b1, 64'd1, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Flush coinciding with an accept includes that product.
      drv(1'b1, 64'd9, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         r32 = $urandom;
         case ($urandom_range(0, 3))
            0:       p = {$urandom, $urandom};
            1:       p = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 9));
            2:       p = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 9));
            default: p = {{32{r32[31]}}, r32};
         endcase
         drv($urandom_range(0, 3) != 0, p, $urandom_range(0, 9) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 4; i++) drv(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Reset mid-block, then in OUTPUT; next block has only post-reset data.
      for (int i = 0; i < 3; i++) drv(1'b1, 64'd1000, 1'b0, 1'b0, 1'b1);
      inValid = 1'b0;
      pulse_reset("rst_mid");
      for (int i = 0; i < 8; i++) drv(1'b1, 64'd50, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      pulse_reset("rst_out");
      for (int i = 0; i < 8; i++) drv(1'b1, 64'd2, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 200 && (m_out || exp_q.size() != 0); i++) idle(1, 1'b1);
      idle(1, 1'b1);
      check_val("drain_queue", 64'(exp_q.size()), 64'd0);
      check_val("blocks_seen_min", {63'd0, n_blocks >= 12}, 64'd1);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter BLOCK_LEN, default 8: number of products per accumulation block (legal range 2..255).
REQ-002 Parameter ACC_W, default 72: internal accumulator width in bits (at least 64 + clog2(BLOCK_LEN)).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 productIn  input  64  signed two's-complement product from the upstream Booth multiplier.
REQ-006 inValid  input  1  productIn is valid this cycle.
REQ-007 inReady  output  1  block accepts productIn this cycle.
REQ-008 clearAcc  input  1  synchronous discard of the partial block.
REQ-009 flush  input  1  request early output of a partial block.
REQ-010 sumOut  output  64  saturated signed block sum.
REQ-011 sumCount  output  8  number of products summed into sumOut.
REQ-012 overflow  output  1  sumOut was saturated; qualified by sumValid.
REQ-013 sumValid  output  1  sumOut, sumCount and overflow are valid.
REQ-014 sumReady  input  1  downstream consumes the result.

Function
REQ-015 The FSM SHALL have exactly two states: ACCUM and OUTPUT.
REQ-016 inReady SHALL equal (state==ACCUM) && !clearAcc.
REQ-017 An accept is inValid && inReady at a rising edge; on accept, acc <= acc + sign-extended productIn and count <= count+1.
REQ-018 When an accept makes count reach BLOCK_LEN, the FSM SHALL enter OUTPUT on the same edge, so sumValid is high in the following cycle (1-cycle latency).
REQ-019 In ACCUM, flush=1 with count>0 and no accept SHALL enter OUTPUT; flush with count==0 SHALL be ignored.
REQ-020 In ACCUM, flush and an accept in the same cycle SHALL include the accepted product and then enter OUTPUT.
REQ-021 In ACCUM, clearAcc SHALL zero acc and count; no product is taken that cycle, and clearAcc overrides flush.
REQ-022 In OUTPUT, sumValid=1 and inReady=0; clearAcc and flush SHALL be ignored.
REQ-023 sumOut SHALL be acc clamped to [-2^63, 2^63-1]: positive excess gives 0x7FFF_FFFF_FFFF_FFFF and negative excess gives 0x8000_0000_0000_0000; overflow=1 exactly when clamping occurred.
REQ-024 sumOut, sumCount and overflow SHALL be registered and held stable while sumValid && !sumReady.
REQ-025 On sumValid && sumReady, the block SHALL zero acc and count and return to ACCUM, so inReady is high in the next cycle.
REQ-026 No input product SHALL be lost or duplicated under any pattern of inValid, sumReady or flush.

Reset
REQ-027 While resetN=0, all of the following SHALL hold immediately, independent of clk: state=ACCUM, acc=0, count=0, sumOut=0, sumCount=0, overflow=0, sumValid=0.
REQ-028 Reset asserted mid-block or in OUTPUT SHALL discard all partial and pending results.
REQ-029 After reset release, the first accept SHALL be possible on the first rising edge.

Structure
REQ-030 The state enum, PRODUCT_W=64 and the saturation limits SHALL reside in the shared multiplier package used by the Booth multiplier.
REQ-031 The block SHALL contain one sub-module, sat_clamp: combinational ACC_W-to-64 clamp producing the overflow flag.

Verification
REQ-032 Eight accepts of 0x1BB6BAA0 with sumReady=1 -> sumOut=0x00000000_DDB5D500, sumCount=8, overflow=0, sumValid one cycle after the 8th accept.
REQ-033 Accepts of 0xFFFFFFFF_F7747564 and 0x10609, then flush -> sumOut=0xFFFFFFFF_F7757B6D, sumCount=2.
REQ-034 Eight accepts of 0x7FFF_FFFF_FFFF_FFFF -> sumOut=0x7FFF_FFFF_FFFF_FFFF, overflow=1; the same with 0x8000_0000_0000_0000 -> 0x8000_0000_0000_0000, overflow=1.
REQ-035 Full block with sumReady=0 for 5 cycles -> sumOut stable, inReady=0, no accepts; sumReady=1 -> inReady=1 on the next cycle.
REQ-036 Three accepts, then clearAcc concurrent with inValid and flush, then 8 accepts of 1 -> sumOut=8, sumCount=8.
REQ-037 resetN pulsed low mid-block and again in OUTPUT -> all outputs 0 immediately; the next block sums only post-reset products.
